// File: rtl/ram_pkg.sv
// Shared types and address helpers for the 2-read/1-write latency RAM.
package ram_pkg;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [63:0] idx;
        logic        in_range;
    } idx_res_t;

    function automatic idx_res_t calc_idx(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] depth
    );
        idx_res_t r;
        logic [63:0] off;
        off        = addr - base;
        r.idx      = off >> WORD_SHIFT;
        r.in_range = (addr >= base) && (r.idx < depth);
        return r;
    endfunction

endpackage

// File: rtl/ram_resp_pipe.sv
// READ_LAT-deep response shift pipeline; stage 0 loads on accept, output is the last stage.
module ram_resp_pipe #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_err,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    logic [READ_LAT-1:0] r_valid;
    logic [READ_LAT-1:0] r_err;
    logic [DATA_W-1:0]   r_data [READ_LAT];

    // Idle stages carry zero data/err so the outputs read 0 between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_err[0]   <= i_valid & i_err;
            r_data[0]  <= i_valid ? i_data : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[READ_LAT-1];
    assign o_err   = r_err[READ_LAT-1];
    assign o_data  = r_data[READ_LAT-1];

endmodule

// File: rtl/ram_2r1w_lat.sv
// Word RAM with an instruction-fetch read port and a data read/write port,
// each with a fixed-latency response pipeline and range/alignment errors.
module ram_2r1w_lat
    import ram_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned READ_LAT  = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_req_valid,
    output logic              imem_req_ready,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_resp_valid,
    output logic [31:0]       imem_resp_data,
    output logic              imem_resp_err,
    input  logic              dmem_req_valid,
    output logic              dmem_req_ready,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_wen,
    input  logic [63:0]       dmem_wdata,
    input  logic [63:0]       dmem_wmask,
    output logic              dmem_resp_valid,
    output logic [63:0]       dmem_resp_rdata,
    output logic              dmem_resp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      r_mem [DEPTH];
    logic             r_ready;

    idx_res_t         w_imem_ix;
    idx_res_t         w_dmem_ix;
    logic [IDX_W-1:0] w_imem_idx;
    logic [IDX_W-1:0] w_dmem_idx;
    logic [63:0]      w_imem_word;
    logic [63:0]      w_dmem_word;
    logic             w_imem_acc;
    logic             w_dmem_acc;
    logic             w_imem_err;
    logic [31:0]      w_imem_data;
    logic             w_dmem_we;
    resp_t            w_dmem_resp;
    logic             w_unused_idx;

    assign w_imem_ix    = calc_idx(64'(imem_addr), BASE_ADDR, 64'(DEPTH));
    assign w_dmem_ix    = calc_idx(64'(dmem_addr), BASE_ADDR, 64'(DEPTH));
    assign w_imem_idx   = w_imem_ix.idx[IDX_W-1:0];
    assign w_dmem_idx   = w_dmem_ix.idx[IDX_W-1:0];
    assign w_unused_idx = &{1'b0, w_imem_ix.idx[63:IDX_W], w_dmem_ix.idx[63:IDX_W]};

    // Ready is rst_n delayed by one edge: low through reset and the cycle after.
    always_ff @(posedge clk) begin
        r_ready <= rst_n;
    end

    assign imem_req_ready = r_ready;
    assign dmem_req_ready = r_ready;
    assign w_imem_acc     = imem_req_valid & r_ready;
    assign w_dmem_acc     = dmem_req_valid & r_ready;

    // Reads sample the array before the edge, so a same-cycle write is not visible.
    assign w_imem_word = r_mem[w_imem_idx];
    assign w_dmem_word = r_mem[w_dmem_idx];

    assign w_imem_err  = ~w_imem_ix.in_range | (imem_addr[1:0] != 2'b00);
    assign w_imem_data = w_imem_err ? 32'h0 :
                         (imem_addr[2] ? w_imem_word[63:32] : w_imem_word[31:0]);

    always_comb begin
        w_dmem_resp.valid = w_dmem_acc;
        w_dmem_resp.err   = ~w_dmem_ix.in_range;
        w_dmem_resp.data  = (dmem_wen | ~w_dmem_ix.in_range) ? 64'h0 : w_dmem_word;
    end

    assign w_dmem_we = w_dmem_acc & dmem_wen & w_dmem_ix.in_range & rst_n;

    always_ff @(posedge clk) begin
        if (w_dmem_we) begin
            r_mem[w_dmem_idx] <= (r_mem[w_dmem_idx] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
        end
    end

    ram_resp_pipe #(
        .DATA_W   (32),
        .READ_LAT (READ_LAT)
    ) u_imem_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_imem_acc),
        .i_data  (w_imem_data),
        .i_err   (w_imem_err),
        .o_valid (imem_resp_valid),
        .o_data  (imem_resp_data),
        .o_err   (imem_resp_err)
    );

    ram_resp_pipe #(
        .DATA_W   (64),
        .READ_LAT (READ_LAT)
    ) u_dmem_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_dmem_resp.valid),
        .i_data  (w_dmem_resp.data),
        .i_err   (w_dmem_resp.err),
        .o_valid (dmem_resp_valid),
        .o_data  (dmem_resp_rdata),
        .o_err   (dmem_resp_err)
    );

endmodule

// File: tb/tb_ram_2r1w_lat.sv
// Directed bench driving a READ_LAT=1 and a READ_LAT=3 instance with identical stimulus.
module tb_ram_2r1w_lat;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [63:0] imem_addr;
    logic        dmem_req_valid;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;

    logic        a_ir, a_iv, a_ie, a_dr, a_dv, a_de;
    logic [31:0] a_idata;
    logic [63:0] a_drdata;
    logic        b_ir, b_iv, b_ie, b_dr, b_dv, b_de;
    logic [31:0] b_idata;
    logic [63:0] b_drdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_2r1w_lat #(.READ_LAT(1)) u_lat1 (
        .clk (clk), .rst_n (rst_n),
        .imem_req_valid (imem_req_valid), .imem_req_ready (a_ir), .imem_addr (imem_addr),
        .imem_resp_valid (a_iv), .imem_resp_data (a_idata), .imem_resp_err (a_ie),
        .dmem_req_valid (dmem_req_valid), .dmem_req_ready (a_dr), .dmem_addr (dmem_addr),
        .dmem_wen (dmem_wen), .dmem_wdata (dmem_wdata), .dmem_wmask (dmem_wmask),
        .dmem_resp_valid (a_dv), .dmem_resp_rdata (a_drdata), .dmem_resp_err (a_de)
    );

    ram_2r1w_lat #(.READ_LAT(3)) u_lat3 (
        .clk (clk), .rst_n (rst_n),
        .imem_req_valid (imem_req_valid), .imem_req_ready (b_ir), .imem_addr (imem_addr),
        .imem_resp_valid (b_iv), .imem_resp_data (b_idata), .imem_resp_err (b_ie),
        .dmem_req_valid (dmem_req_valid), .dmem_req_ready (b_dr), .dmem_addr (dmem_addr),
        .dmem_wen (dmem_wen), .dmem_wdata (dmem_wdata), .dmem_wmask (dmem_wmask),
        .dmem_resp_valid (b_dv), .dmem_resp_rdata (b_drdata), .dmem_resp_err (b_de)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_wen       = 1'b0;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, ".a_ir"}, 64'(a_ir), 64'(exp));
        chk({tag, ".a_dr"}, 64'(a_dr), 64'(exp));
        chk({tag, ".b_ir"}, 64'(b_ir), 64'(exp));
        chk({tag, ".b_dr"}, 64'(b_dr), 64'(exp));
    endtask

    task automatic no_valid(input string tag);
        chk({tag, ".a_iv"}, 64'(a_iv), 64'd0);
        chk({tag, ".a_dv"}, 64'(a_dv), 64'd0);
        chk({tag, ".b_iv"}, 64'(b_iv), 64'd0);
        chk({tag, ".b_dv"}, 64'(b_dv), 64'd0);
    endtask

    // One data request; lat-1 response checked after the accept edge, lat-3 two edges later.
    task automatic dmem_op(input string tag, input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] wmask,
                           input logic [63:0] exp_rd, input logic exp_err);
        dmem_req_valid = 1'b1;
        dmem_wen       = wen;
        dmem_addr      = addr;
        dmem_wdata     = wdata;
        dmem_wmask     = wmask;
        tick();
        idle();
        chk({tag, ".a_v"},   64'(a_dv), 64'd1);
        chk({tag, ".a_rd"},  a_drdata,  exp_rd);
        chk({tag, ".a_err"}, 64'(a_de), 64'(exp_err));
        tick();
        chk({tag, ".a_v_off"}, 64'(a_dv), 64'd0);
        chk({tag, ".b_v_early"}, 64'(b_dv), 64'd0);
        tick();
        chk({tag, ".b_v"},   64'(b_dv), 64'd1);
        chk({tag, ".b_rd"},  b_drdata,  exp_rd);
        chk({tag, ".b_err"}, 64'(b_de), 64'(exp_err));
    endtask

    task automatic fetch_op(input string tag, input logic [63:0] addr,
                            input logic [31:0] exp_d, input logic exp_err);
        imem_req_valid = 1'b1;
        imem_addr      = addr;
        tick();
        idle();
        chk({tag, ".a_v"},   64'(a_iv),    64'd1);
        chk({tag, ".a_d"},   64'(a_idata), 64'(exp_d));
        chk({tag, ".a_err"}, 64'(a_ie),    64'(exp_err));
        tick();
        chk({tag, ".b_v_early"}, 64'(b_iv), 64'd0);
        tick();
        chk({tag, ".b_v"},   64'(b_iv),    64'd1);
        chk({tag, ".b_d"},   64'(b_idata), 64'(exp_d));
        chk({tag, ".b_err"}, 64'(b_ie),    64'(exp_err));
    endtask

    initial begin
        rst_n      = 1'b0;
        idle();
        imem_addr  = 64'h0;
        dmem_addr  = 64'h0;
        dmem_wdata = 64'h0;
        dmem_wmask = 64'h0;

        // Reset state
        tick();
        tick();
        chk_ready("rst", 1'b0);
        no_valid("rst");
        chk("rst.a_idata", 64'(a_idata), 64'd0);
        chk("rst.a_drdata", a_drdata, 64'd0);
        chk("rst.b_err", 64'(b_de | b_ie), 64'd0);
        rst_n = 1'b1;
        chk_ready("rel0", 1'b0);
        tick();
        chk_ready("rel1", 1'b1);

        // Basic write then read
        dmem_op("wr10", 1'b1, BASE + 64'h10, 64'h1122_3344_5566_7788, ONES, 64'h0, 1'b0);
        dmem_op("rd10", 1'b0, BASE + 64'h10, 64'h0, 64'h0, 64'h1122_3344_5566_7788, 1'b0);

        // Back-to-back fetches of both halves
        imem_req_valid = 1'b1;
        imem_addr      = BASE + 64'h10;
        tick();
        imem_addr      = BASE + 64'h14;
        chk("b2b.a0.v", 64'(a_iv), 64'd1);
        chk("b2b.a0.d", 64'(a_idata), 64'h5566_7788);
        tick();
        idle();
        chk("b2b.a1.v", 64'(a_iv), 64'd1);
        chk("b2b.a1.d", 64'(a_idata), 64'h1122_3344);
        tick();
        chk("b2b.a2.v", 64'(a_iv), 64'd0);
        chk("b2b.b0.v", 64'(b_iv), 64'd1);
        chk("b2b.b0.d", 64'(b_idata), 64'h5566_7788);
        tick();
        chk("b2b.b1.v", 64'(b_iv), 64'd1);
        chk("b2b.b1.d", 64'(b_idata), 64'h1122_3344);

        // Bit-masked writes
        dmem_op("wr0",  1'b1, BASE, 64'h0, ONES, 64'h0, 1'b0);
        dmem_op("wr0m", 1'b1, BASE, ONES, 64'h0000_0000_FFFF_0000, 64'h0, 1'b0);
        dmem_op("rd0",  1'b0, BASE, 64'h0, 64'h0, 64'h0000_0000_FFFF_0000, 1'b0);
        dmem_op("wr8",  1'b1, BASE + 64'h8, 64'h1234_5678_9ABC_DEF0, ONES, 64'h0, 1'b0);
        dmem_op("wr8m", 1'b1, BASE + 64'h8, ONES, 64'h0000_0000_FFFF_0000, 64'h0, 1'b0);
        dmem_op("rd8",  1'b0, BASE + 64'h8, 64'h0, 64'h0, 64'h1234_5678_FFFF_DEF0, 1'b0);

        // Same-cycle write and fetch of idx 5
        dmem_op("wr28", 1'b1, BASE + 64'h28, 64'h0123_4567_89AB_CDEF, ONES, 64'h0, 1'b0);
        dmem_req_valid = 1'b1;
        dmem_wen       = 1'b1;
        dmem_addr      = BASE + 64'h28;
        dmem_wdata     = 64'hAA;
        dmem_wmask     = ONES;
        imem_req_valid = 1'b1;
        imem_addr      = BASE + 64'h28;
        tick();
        dmem_req_valid = 1'b0;
        dmem_wen       = 1'b0;
        chk("col.a0.d", 64'(a_idata), 64'h89AB_CDEF);
        chk("col.a.wr_v", 64'(a_dv), 64'd1);
        chk("col.a.wr_rd", a_drdata, 64'h0);
        tick();
        idle();
        chk("col.a1.d", 64'(a_idata), 64'h0000_00AA);
        tick();
        chk("col.b0.d", 64'(b_idata), 64'h89AB_CDEF);
        tick();
        chk("col.b1.d", 64'(b_idata), 64'h0000_00AA);

        // Range and alignment errors
        fetch_op("f_low", 64'h7FFF_FFFC, 32'h0, 1'b1);
        dmem_op("rd_low", 1'b0, 64'h7FFF_FFF8, 64'h0, 64'h0, 64'h0, 1'b1);
        dmem_op("rd_oor", 1'b0, BASE + 64'h8000, 64'h0, 64'h0, 64'h0, 1'b1);
        dmem_op("wr_last", 1'b1, BASE + 64'h7FF8, 64'hCAFE_F00D_1234_5678, ONES, 64'h0, 1'b0);
        dmem_op("wr_oor", 1'b1, BASE + 64'h8000, ONES, ONES, 64'h0, 1'b1);
        dmem_op("rd0_kept", 1'b0, BASE, 64'h0, 64'h0, 64'h0000_0000_FFFF_0000, 1'b0);
        dmem_op("rd_last", 1'b0, BASE + 64'h7FF8, 64'h0, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0);
        fetch_op("f_last", BASE + 64'h7FFC, 32'hCAFE_F00D, 1'b0);
        fetch_op("f_mis", BASE + 64'h2, 32'h0, 1'b1);

        // Reset with requests in flight; a write during reset must not land
        imem_req_valid = 1'b1;
        imem_addr      = BASE + 64'h10;
        dmem_req_valid = 1'b1;
        dmem_addr      = BASE + 64'h28;
        tick();
        imem_addr      = BASE + 64'h14;
        dmem_addr      = BASE;
        tick();
        imem_addr      = BASE + 64'h28;
        dmem_addr      = BASE + 64'h10;
        dmem_wen       = 1'b1;
        dmem_wdata     = 64'hDEAD_BEEF_DEAD_BEEF;
        dmem_wmask     = ONES;
        rst_n          = 1'b0;
        tick();
        idle();
        chk_ready("ifl0", 1'b0);
        no_valid("ifl0");
        tick();
        rst_n = 1'b1;
        chk_ready("ifl1", 1'b0);
        no_valid("ifl1");
        tick();
        chk_ready("ifl2", 1'b1);
        no_valid("ifl2");
        tick();
        no_valid("ifl3");
        tick();
        no_valid("ifl4");
        dmem_op("post_rd10", 1'b0, BASE + 64'h10, 64'h0, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
        dmem_op("post_rd28", 1'b0, BASE + 64'h28, 64'h0, 64'h0, 64'h0000_0000_0000_00AA, 1'b0);
        fetch_op("post_f14", BASE + 64'h14, 32'h1122_3344, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
